// File: rtl/alocador_de_vagas.sv
// Parking-lot spot allocator: lowest-free-spot allocation, exit release, gate timing, occupancy counts.
// Latency: allocation and release take effect at the sampling edge; Negado/Erro are one-cycle registered pulses.
// Backpressure: none; Entrada is ignored outside OCIOSO and must drop to 0 before a new request.
module alocador_de_vagas #(
    parameter int TEMPO_CANCELA = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Entrada,
    input  logic       Saida,
    input  logic [2:0] VagaSaida,
    output logic [7:0] Vagas,
    output logic [2:0] VagaAtribuida,
    output logic       Cancela,
    output logic       Negado,
    output logic       Erro,
    output logic [3:0] Ocupadas,
    output logic [3:0] Livres
);

    localparam logic [1:0] OCIOSO = 2'd0;
    localparam logic [1:0] ABERTA = 2'd1;
    localparam logic [1:0] ESPERA = 2'd2;

    localparam logic [3:0] TEMPO_L = 4'(TEMPO_CANCELA);

    logic [1:0] estado_q, estado_d;
    logic [3:0] timer_q, timer_d;
    logic [7:0] vagas_q, vagas_d;
    logic [2:0] vaga_atribuida_q, vaga_atribuida_d;
    logic       negado_q, negado_d;
    logic       erro_q, erro_d;
    logic [3:0] ocupadas_q, ocupadas_d;
    logic [3:0] livres_q, livres_d;

    logic [2:0] livre_idx;
    logic       cheio;
    logic       aloca;
    logic       libera;

    // Lowest-index free spot; scan downwards so the smallest index wins.
    always_comb begin
        livre_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!vagas_q[i]) begin
                livre_idx = 3'(i);
            end
        end
    end

    assign cheio  = (vagas_q == 8'hFF);
    assign aloca  = (estado_q == OCIOSO) && Entrada && !cheio;
    assign libera = Saida && vagas_q[VagaSaida];

    always_comb begin
        estado_d         = estado_q;
        timer_d          = timer_q;
        vaga_atribuida_d = vaga_atribuida_q;
        negado_d         = 1'b0;
        erro_d           = Saida && !vagas_q[VagaSaida];
        vagas_d          = vagas_q;

        case (estado_q)
            OCIOSO: begin
                if (Entrada) begin
                    if (cheio) begin
                        estado_d = ESPERA;
                        negado_d = 1'b1;
                    end else begin
                        estado_d         = ABERTA;
                        timer_d          = TEMPO_L;
                        vaga_atribuida_d = livre_idx;
                    end
                end
            end
            ABERTA: begin
                if (timer_q <= 4'd1) begin
                    timer_d  = 4'd0;
                    estado_d = Entrada ? ESPERA : OCIOSO;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            ESPERA: begin
                if (!Entrada) begin
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
                timer_d  = 4'd0;
            end
        endcase

        // A release of the spot being allocated sees a free bit, so it never clears the new allocation.
        if (aloca) begin
            vagas_d[livre_idx] = 1'b1;
        end
        if (libera) begin
            vagas_d[VagaSaida] = 1'b0;
        end

        ocupadas_d = ocupadas_q + {3'd0, aloca} - {3'd0, libera};
        livres_d   = 4'd8 - ocupadas_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q         <= OCIOSO;
            timer_q          <= 4'd0;
            vagas_q          <= 8'd0;
            vaga_atribuida_q <= 3'd0;
            negado_q         <= 1'b0;
            erro_q           <= 1'b0;
            ocupadas_q       <= 4'd0;
            livres_q         <= 4'd8;
        end else begin
            estado_q         <= estado_d;
            timer_q          <= timer_d;
            vagas_q          <= vagas_d;
            vaga_atribuida_q <= vaga_atribuida_d;
            negado_q         <= negado_d;
            erro_q           <= erro_d;
            ocupadas_q       <= ocupadas_d;
            livres_q         <= livres_d;
        end
    end

    assign Vagas         = vagas_q;
    assign VagaAtribuida = vaga_atribuida_q;
    assign Cancela       = (estado_q == ABERTA);
    assign Negado        = negado_q;
    assign Erro          = erro_q;
    assign Ocupadas      = ocupadas_q;
    assign Livres        = livres_q;

endmodule

// File: tb/tb_alocador_de_vagas.sv
// Directed bench for alocador_de_vagas with TEMPO_CANCELA=4.
module tb_alocador_de_vagas;

    logic       clk = 1'b0;
    logic       reset;
    logic       Entrada;
    logic       Saida;
    logic [2:0] VagaSaida;
    logic [7:0] Vagas;
    logic [2:0] VagaAtribuida;
    logic       Cancela;
    logic       Negado;
    logic       Erro;
    logic [3:0] Ocupadas;
    logic [3:0] Livres;

    int checks = 0;
    int passed = 0;

    alocador_de_vagas #(.TEMPO_CANCELA(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .Entrada      (Entrada),
        .Saida        (Saida),
        .VagaSaida    (VagaSaida),
        .Vagas        (Vagas),
        .VagaAtribuida(VagaAtribuida),
        .Cancela      (Cancela),
        .Negado       (Negado),
        .Erro         (Erro),
        .Ocupadas     (Ocupadas),
        .Livres       (Livres)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full service of one request: one sampling edge, then the gate period with Entrada low.
    task automatic do_entry();
        Entrada = 1'b1;
        tick();
        Entrada = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; Entrada = 1'b0; Saida = 1'b0; VagaSaida = 3'd0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (Vagas !== 8'h00) $display("FAIL reset_vagas got=%h exp=00", Vagas); else passed++;
        checks++; if (VagaAtribuida !== 3'd0) $display("FAIL reset_va got=%0d exp=0", VagaAtribuida); else passed++;
        checks++; if (Cancela !== 1'b0) $display("FAIL reset_cancela got=%b exp=0", Cancela); else passed++;
        checks++; if (Negado !== 1'b0 || Erro !== 1'b0) $display("FAIL reset_pulses got=%b%b exp=00", Negado, Erro); else passed++;
        checks++; if (Ocupadas !== 4'd0 || Livres !== 4'd8) $display("FAIL reset_counts got=%0d/%0d exp=0/8", Ocupadas, Livres); else passed++;
    endtask

    task automatic test_single_entry();
        Entrada = 1'b1;
        tick();
        Entrada = 1'b0;
        checks++; if (Vagas !== 8'h01) $display("FAIL single_vagas got=%h exp=01", Vagas); else passed++;
        checks++; if (VagaAtribuida !== 3'd0) $display("FAIL single_va got=%0d exp=0", VagaAtribuida); else passed++;
        checks++; if (Ocupadas !== 4'd1 || Livres !== 4'd7) $display("FAIL single_counts got=%0d/%0d exp=1/7", Ocupadas, Livres); else passed++;
        checks++; if (Cancela !== 1'b1) $display("FAIL single_cancela_c0 got=%b exp=1", Cancela); else passed++;
        for (int k = 1; k < 4; k++) begin
            tick();
            checks++; if (Cancela !== 1'b1) $display("FAIL single_cancela_c%0d got=%b exp=1", k, Cancela); else passed++;
        end
        tick();
        checks++; if (Cancela !== 1'b0) $display("FAIL single_cancela_fall got=%b exp=0", Cancela); else passed++;
    endtask

    task automatic test_fill();
        for (int k = 1; k < 8; k++) begin
            Entrada = 1'b1;
            tick();
            Entrada = 1'b0;
            checks++; if (VagaAtribuida !== 3'(k)) $display("FAIL fill_va got=%0d exp=%0d", VagaAtribuida, k); else passed++;
            repeat (4) tick();
        end
        checks++; if (Vagas !== 8'hFF) $display("FAIL fill_vagas got=%h exp=ff", Vagas); else passed++;
        checks++; if (Ocupadas !== 4'd8 || Livres !== 4'd0) $display("FAIL fill_counts got=%0d/%0d exp=8/0", Ocupadas, Livres); else passed++;
        Entrada = 1'b1;
        tick();
        Entrada = 1'b0;
        checks++; if (Negado !== 1'b1) $display("FAIL full_negado got=%b exp=1", Negado); else passed++;
        checks++; if (Cancela !== 1'b0) $display("FAIL full_cancela got=%b exp=0", Cancela); else passed++;
        checks++; if (Vagas !== 8'hFF) $display("FAIL full_vagas got=%h exp=ff", Vagas); else passed++;
        tick();
        checks++; if (Negado !== 1'b0) $display("FAIL full_negado_len got=%b exp=0", Negado); else passed++;
    endtask

    task automatic test_full_release();
        Entrada = 1'b1; Saida = 1'b1; VagaSaida = 3'd3;
        tick();
        Entrada = 1'b0; Saida = 1'b0;
        checks++; if (Negado !== 1'b1) $display("FAIL fullrel_negado got=%b exp=1", Negado); else passed++;
        checks++; if (Vagas !== 8'hF7) $display("FAIL fullrel_vagas got=%h exp=f7", Vagas); else passed++;
        checks++; if (Ocupadas !== 4'd7 || Livres !== 4'd1) $display("FAIL fullrel_counts got=%0d/%0d exp=7/1", Ocupadas, Livres); else passed++;
        checks++; if (Cancela !== 1'b0 || Erro !== 1'b0) $display("FAIL fullrel_cancela_erro got=%b%b exp=00", Cancela, Erro); else passed++;
        tick();
        Entrada = 1'b1;
        tick();
        Entrada = 1'b0;
        checks++; if (VagaAtribuida !== 3'd3) $display("FAIL fullrel_realloc_va got=%0d exp=3", VagaAtribuida); else passed++;
        checks++; if (Vagas !== 8'hFF || Cancela !== 1'b1) $display("FAIL fullrel_realloc got=%h/%b exp=ff/1", Vagas, Cancela); else passed++;
        repeat (4) tick();
    endtask

    task automatic test_simultaneous();
        // Bring Vagas from ff down to 05.
        Saida = 1'b1;
        for (int k = 1; k < 8; k++) begin
            if (k != 2) begin
                VagaSaida = 3'(k);
                tick();
            end
        end
        Saida = 1'b0;
        checks++; if (Vagas !== 8'h05 || Ocupadas !== 4'd2) $display("FAIL simul_setup got=%h/%0d exp=05/2", Vagas, Ocupadas); else passed++;
        Entrada = 1'b1; Saida = 1'b1; VagaSaida = 3'd0;
        tick();
        Entrada = 1'b0; Saida = 1'b0;
        checks++; if (Vagas !== 8'h06) $display("FAIL simul_vagas got=%h exp=06", Vagas); else passed++;
        checks++; if (VagaAtribuida !== 3'd1) $display("FAIL simul_va got=%0d exp=1", VagaAtribuida); else passed++;
        checks++; if (Ocupadas !== 4'd2 || Livres !== 4'd6) $display("FAIL simul_counts got=%0d/%0d exp=2/6", Ocupadas, Livres); else passed++;
        checks++; if (Erro !== 1'b0) $display("FAIL simul_erro got=%b exp=0", Erro); else passed++;
        repeat (4) tick();
    endtask

    task automatic test_erro();
        Saida = 1'b1;
        VagaSaida = 3'd1; tick();
        VagaSaida = 3'd2; tick();
        Saida = 1'b0;
        do_entry();
        checks++; if (Vagas !== 8'h01) $display("FAIL erro_setup got=%h exp=01", Vagas); else passed++;
        Saida = 1'b1; VagaSaida = 3'd6;
        tick();
        Saida = 1'b0;
        checks++; if (Erro !== 1'b1) $display("FAIL erro_pulse got=%b exp=1", Erro); else passed++;
        checks++; if (Vagas !== 8'h01 || Ocupadas !== 4'd1) $display("FAIL erro_state got=%h/%0d exp=01/1", Vagas, Ocupadas); else passed++;
        tick();
        checks++; if (Erro !== 1'b0) $display("FAIL erro_len got=%b exp=0", Erro); else passed++;
        // Release of the very spot being allocated this cycle.
        Entrada = 1'b1; Saida = 1'b1; VagaSaida = 3'd1;
        tick();
        Entrada = 1'b0; Saida = 1'b0;
        checks++; if (Erro !== 1'b1) $display("FAIL samespot_erro got=%b exp=1", Erro); else passed++;
        checks++; if (Vagas !== 8'h03 || VagaAtribuida !== 3'd1) $display("FAIL samespot_alloc got=%h/%0d exp=03/1", Vagas, VagaAtribuida); else passed++;
        checks++; if (Ocupadas !== 4'd2 || Livres !== 4'd6) $display("FAIL samespot_counts got=%0d/%0d exp=2/6", Ocupadas, Livres); else passed++;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        Entrada = 1'b1;
        tick();
        checks++; if (Vagas !== 8'h07 || Cancela !== 1'b1) $display("FAIL mid_alloc got=%h/%b exp=07/1", Vagas, Cancela); else passed++;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (Cancela !== 1'b0 || Vagas !== 8'h00) $display("FAIL mid_reset got=%b/%h exp=0/00", Cancela, Vagas); else passed++;
        checks++; if (Ocupadas !== 4'd0 || Livres !== 4'd8 || VagaAtribuida !== 3'd0) $display("FAIL mid_reset_counts got=%0d/%0d/%0d exp=0/8/0", Ocupadas, Livres, VagaAtribuida); else passed++;
        tick();
        checks++; if (Vagas !== 8'h01 || VagaAtribuida !== 3'd0 || Cancela !== 1'b1) $display("FAIL mid_realloc got=%h/%0d/%b exp=01/0/1", Vagas, VagaAtribuida, Cancela); else passed++;
        checks++; if (Ocupadas !== 4'd1 || Livres !== 4'd7) $display("FAIL mid_realloc_counts got=%0d/%0d exp=1/7", Ocupadas, Livres); else passed++;
    endtask

    task automatic test_back_to_back();
        // Entrada still held from the previous task: gate expires into ESPERA, no re-allocation.
        repeat (4) tick();
        checks++; if (Cancela !== 1'b0) $display("FAIL hold_cancela got=%b exp=0", Cancela); else passed++;
        tick();
        checks++; if (Vagas !== 8'h01 || Ocupadas !== 4'd1) $display("FAIL hold_no_alloc got=%h/%0d exp=01/1", Vagas, Ocupadas); else passed++;
        Entrada = 1'b0;
        tick();
        Entrada = 1'b1;
        tick();
        Entrada = 1'b0;
        checks++; if (Vagas !== 8'h03 || VagaAtribuida !== 3'd1 || Cancela !== 1'b1) $display("FAIL b2b_alloc got=%h/%0d/%b exp=03/1/1", Vagas, VagaAtribuida, Cancela); else passed++;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_single_entry();
        test_fill();
        test_full_release();
        test_simultaneous();
        test_erro();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/alocador_de_vagas.md
# alocador_de_vagas

Sequential spot-allocation controller for the 8-spot parking lot. It accepts entry requests from the entrance gate and assigns the lowest-numbered free spot. It accepts exit releases by spot index, drives the entrance gate (Cancela) for a fixed time, and maintains the 8-bit occupancy vector Vagas together with registered Ocupadas/Livres counts. Vagas is the occupancy vector consumed by the parking-lot spot adder.

## Interface
Parameters:
- TEMPO_CANCELA, default 4: number of cycles the gate stays open after a successful allocation (legal range 1..15).

Ports:
- clk  input  1  single system clock, all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Entrada  input  1  entry request, level; a new request requires a return to 0 after each service.
- Saida  input  1  exit release strobe, sampled every cycle.
- VagaSaida  input  3  index of the spot being released; valid when Saida=1.
- Vagas  output  8  occupancy vector, bit i=1 means spot i occupied.
- VagaAtribuida  output  3  index of the last allocated spot.
- Cancela  output  1  gate open.
- Negado  output  1  one-cycle pulse: entry refused, lot full.
- Erro  output  1  one-cycle pulse: release of a spot already free.
- Ocupadas  output  4  occupied count, 0..8.
- Livres  output  4  free count, always 8 - Ocupadas.

## Operation
- Reset values: Vagas=0, VagaAtribuida=0, Cancela=0, Negado=0, Erro=0, Ocupadas=0, Livres=8, state OCIOSO, gate timer=0.
- FSM states:
  - OCIOSO. If Entrada=1 and Vagas!=8'hFF, go to ABERTA. If Entrada=1 and Vagas==8'hFF, go to ESPERA and pulse Negado.
  - ABERTA. Cancela=1 and the timer counts down from TEMPO_CANCELA. At expiry, go to ESPERA if Entrada=1, otherwise go to OCIOSO.
  - ESPERA. Cancela=0. Stay until Entrada=0, then go to OCIOSO.
- Allocation on the OCIOSO→ABERTA transition:
  - Take the lowest index i with Vagas[i]=0, using the register value before any same-cycle release.
  - Set Vagas[i] and load VagaAtribuida=i.
- Fullness is judged on the pre-release Vagas. A same-cycle release does not rescue a request that sees a full lot; that request is refused.
- Entrada in ABERTA and ESPERA is ignored and not queued.
- Release is independent of the FSM and is accepted in every state:
  - Saida=1 and Vagas[VagaSaida]=1: clear that bit.
  - Saida=1 and Vagas[VagaSaida]=0: pulse Erro, Vagas unchanged.
- Simultaneous allocation and valid release in one cycle: both are applied, and Ocupadas is unchanged (net 0).
- A release naming the spot being allocated in the same cycle is necessarily a free bit. It raises Erro, and the allocation still proceeds.
- Ocupadas update per cycle: +1 on allocation, -1 on valid release. It is never below 0 or above 8 by construction. Livres is registered alongside as 8 - Ocupadas.
- Invariant: Ocupadas equals popcount(Vagas) every cycle.

## Timing
- Allocation latency is 1 cycle. With Entrada=1 sampled in OCIOSO at edge T:
  - From T, Vagas, VagaAtribuida, Ocupadas and Livres are updated and Cancela=1.
  - Cancela stays high for exactly TEMPO_CANCELA cycles and falls at edge T+TEMPO_CANCELA.
- Negado and Erro are registered, high for exactly one cycle after the sampling edge.
- Release latency is 1 cycle: the bit clears and the counts update at the next edge.
- Reset mid-operation (e.g. Cancela open) returns all outputs to reset values at the reset edge. Cancela drops at that same edge, and the timer and FSM restart in OCIOSO.
- Reset dominates Entrada and Saida in the same cycle.
- Minimum interval between two successful allocations: TEMPO_CANCELA+1 cycles, since Entrada must drop for one cycle.

## Test plan
- Reset then Entrada pulse (high 1 cycle):
  - Vagas=8'h01, VagaAtribuida=0, Ocupadas=1, Livres=7.
  - Cancela high exactly 4 cycles, then back to OCIOSO.
- Eight serviced entries, then a ninth:
  - After the eighth: Vagas=8'hFF, Ocupadas=8, Livres=0.
  - The ninth produces Negado for 1 cycle, Cancela stays 0, Vagas unchanged.
- Full lot with Entrada=1 and Saida=1, VagaSaida=3 in the same cycle:
  - Negado pulses and bit 3 clears, so Vagas=8'hF7, Ocupadas=7.
  - After Entrada drops, a new request allocates spot 3.
- Vagas=8'h05 with entry and release of spot 0 in the same cycle:
  - Spot 1 is allocated and spot 0 cleared, so Vagas=8'h06.
  - Ocupadas stays 2.
- Release of a free spot 6 with Vagas=8'h01: Erro pulses 1 cycle, Vagas and Ocupadas unchanged.
- Reset asserted on the 2nd cycle of Cancela with Entrada held:
  - All outputs return to reset values at the next edge.
  - With Entrada still high after reset, a new allocation of spot 0 occurs.
